sseg_scan_decoder: RTL

Receive-side monitor for the multiplexed seven-segment display bus (`sseg`/`an`) driven by the lab display controllers. It samples the time-multiplexed anode scan and waits for each digit window to settle. It decodes each lit glyph back to a symbol code and publishes a complete four-digit frame once every anode has been seen. It sits beside the display driver in simulation benches and on-board self-check builds, so displayed results can be compared against expected values without visual inspection.

---
 rtl/sseg_pkg.sv | 60 ++++++
 rtl/sseg_glyph_decode.sv | 39 +++
 rtl/sseg_scan_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
package sseg_pkg;

    // Decoded symbol code: 0-15 hex digits, plus the special codes below.
    typedef logic [4:0] sym_t;

    localparam sym_t SYM_BLANK   = 5'd16;
    localparam sym_t SYM_MINUS   = 5'd17;
    localparam sym_t SYM_INVALID = 5'd31;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;   // lowercase b
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;   // lowercase d
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Scan FSM: WAIT for a settled single-digit window, HOLD until it changes.
    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } scan_state_t;

    // True when exactly one anode (active-low) is driven.
    function automatic logic single_anode(input logic [3:0] an);
        logic ok;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Index of the driven anode; only meaningful when single_anode() holds.
    function automatic logic [1:0] anode_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational decode of an active-low 7-segment glyph into a symbol code.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output sym_t       sym
);

    logic [6:0] seg_s;

    assign seg_s = ~seg_n;

    // Map the lit-segment pattern to its symbol; anything unrecognised is INVALID.
    always_comb begin
        sym = SYM_INVALID;
        case (seg_s)
            SEG_HEX_0: sym = 5'd0;
            SEG_HEX_1: sym = 5'd1;
            SEG_HEX_2: sym = 5'd2;
            SEG_HEX_3: sym = 5'd3;
            SEG_HEX_4: sym = 5'd4;
            SEG_HEX_5: sym = 5'd5;
            SEG_HEX_6: sym = 5'd6;
            SEG_HEX_7: sym = 5'd7;
            SEG_HEX_8: sym = 5'd8;
            SEG_HEX_9: sym = 5'd9;
            SEG_HEX_A: sym = 5'd10;
            SEG_HEX_B: sym = 5'd11;
            SEG_HEX_C: sym = 5'd12;
            SEG_HEX_D: sym = 5'd13;
            SEG_HEX_E: sym = 5'd14;
            SEG_HEX_F: sym = 5'd15;
            SEG_BLANK: sym = SYM_BLANK;
            SEG_MINUS: sym = SYM_MINUS;
            default:   sym = SYM_INVALID;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus and rebuilds four-digit frames.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  sseg,
    input  logic [3:0]  an,
    output logic [19:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        scan_lost
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]        SETTLE_C  = 4'(SETTLE);
    localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

    logic [7:0]        r_sseg;
    logic [3:0]        r_an;
    logic [3:0]        stab_r;
    logic [3:0]        stab_s;
    scan_state_t       state_r;
    scan_state_t       state_s;
    logic              capture_s;
    sym_t              sym_s;
    logic [1:0]        slot_s;
    logic [3:0]        mask_r;
    logic [3:0]        mask_upd_s;
    logic [3:0][4:0]   stage_r;
    logic [3:0][4:0]   stage_upd_s;
    logic [3:0]        dp_stage_r;
    logic [3:0]        dp_upd_s;
    logic              frame_done_s;
    logic              err_s;
    logic [IDLE_W-1:0] idle_r;

    sseg_glyph_decode u_glyph (
        .seg_n (r_sseg[6:0]),
        .sym   (sym_s)
    );

    assign slot_s = anode_index(r_an);

    // Stability count: zero when the bus just changed, else count up and saturate.
    always_comb begin
        stab_s = stab_r;
        if ({sseg, an} != {r_sseg, r_an}) begin
            stab_s = 4'd0;
        end else if (stab_r == SETTLE_C) begin
            stab_s = stab_r;
        end else begin
            stab_s = stab_r + 4'd1;
        end
    end

    // Register the bus once and track how long it has been unchanged.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sseg <= 8'hFF;
            r_an   <= 4'hF;
            stab_r <= 4'd0;
        end else begin
            r_sseg <= sseg;
            r_an   <= an;
            stab_r <= stab_s;
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= WAIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture once per settled single-anode window; re-arm when the bus moves.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        case (state_r)
            WAIT: begin
                if ((stab_s == SETTLE_C) && single_anode(r_an)) begin
                    capture_s = 1'b1;
                    state_s   = HOLD;
                end else begin
                    state_s   = WAIT;
                end
            end
            HOLD: begin
                if (stab_s == 4'd0) begin
                    state_s = WAIT;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = WAIT;
            end
        endcase
    end

    // Staging contents as they will look after this cycle's capture (newest wins).
    always_comb begin
        stage_upd_s = stage_r;
        dp_upd_s    = dp_stage_r;
        mask_upd_s  = mask_r;
        if (capture_s) begin
            stage_upd_s[slot_s] = sym_s;
            dp_upd_s[slot_s]    = ~r_sseg[7];
            mask_upd_s[slot_s]  = 1'b1;
        end else begin
            stage_upd_s = stage_r;
        end
        frame_done_s = capture_s && (mask_upd_s == 4'hF);
        err_s        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            err_s = err_s | (stage_upd_s[i] == SYM_INVALID);
        end
    end

    // Staging, frame publication and scan-loss supervision.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stage_r     <= {4{SYM_BLANK}};
            dp_stage_r  <= 4'h0;
            mask_r      <= 4'h0;
            digits      <= {4{SYM_BLANK}};
            dp          <= 4'h0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            scan_lost   <= 1'b0;
            idle_r      <= '0;
        end else begin
            stage_r     <= stage_upd_s;
            dp_stage_r  <= dp_upd_s;
            frame_valid <= frame_done_s;
            if (frame_done_s) begin
                digits    <= stage_upd_s;
                dp        <= dp_upd_s;
                frame_err <= err_s;
                mask_r    <= 4'h0;
            end else if (capture_s) begin
                mask_r    <= mask_upd_s;
            end else if (idle_r == TIMEOUT_C) begin
                // A stalled scan abandons any partially collected frame.
                mask_r    <= 4'h0;
            end else begin
                mask_r    <= mask_r;
            end
            if (capture_s) begin
                idle_r    <= '0;
                scan_lost <= 1'b0;
            end else if (idle_r == TIMEOUT_C) begin
                idle_r    <= idle_r;
                scan_lost <= 1'b1;
            end else begin
                idle_r    <= idle_r + 1'b1;
                scan_lost <= scan_lost;
            end
        end
    end

endmodule
